// File: rtl/iir_biquad_if.sv
// Sample-stream bundle for the biquad: input handshake, per-sample coefficients,
// and the output handshake with its saturation flag.
interface iir_biquad_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
);
    logic signed [DATA_W-1:0] x_in;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] b0;
    logic signed [COEF_W-1:0] b1;
    logic signed [COEF_W-1:0] b2;
    logic signed [COEF_W-1:0] a1;
    logic signed [COEF_W-1:0] a2;
    logic signed [DATA_W-1:0] y_out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sat;

    modport slave (
        input  x_in, in_valid, b0, b1, b2, a1, a2, out_ready,
        output in_ready, y_out, out_valid, sat
    );

    modport master (
        output x_in, in_valid, b0, b1, b2, a1, a2, out_ready,
        input  in_ready, y_out, out_valid, sat
    );
endinterface

// File: rtl/iir_biquad.sv
// Direct Form I biquad with one time-shared multiplier: five MAC cycles per sample,
// then round-half-up, saturate, and hold the result until downstream takes it.
module iir_biquad #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int ACC_W  = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    iir_biquad_if.slave  bus
);
    localparam int PROD_W = COEF_W + DATA_W;
    localparam logic signed [ACC_W-1:0] ONE   = 1;
    localparam logic signed [ACC_W-1:0] Y_MAX = (ONE <<< (DATA_W-1)) - ONE;
    localparam logic signed [ACC_W-1:0] Y_MIN = -(ONE <<< (DATA_W-1));
    localparam logic signed [ACC_W-1:0] RND   = ONE <<< (FRAC-1);

    typedef enum logic [1:0] {IDLE, MAC, FIN, HOLD} state_t;

    state_t                   state_q;
    logic [2:0]               cnt_q;
    logic signed [DATA_W-1:0] x0_q, x1_q, x2_q, y1_q, y2_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] y_out_q;
    logic                     out_valid_q;
    logic                     sat_q;

    logic signed [COEF_W-1:0] coef_in [0:4];
    logic signed [COEF_W-1:0] coef_q  [0:4];
    logic                     accept;

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign coef_in[0] = bus.b0;
    assign coef_in[1] = bus.b1;
    assign coef_in[2] = bus.b2;
    assign coef_in[3] = bus.a1;
    assign coef_in[4] = bus.a2;

    // Coefficients are snapshotted at acceptance so retuning mid-sample is harmless.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_coef
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    coef_q[gi] <= '0;
                end else if (accept) begin
                    coef_q[gi] <= coef_in[gi];
                end
            end
        end
    endgenerate

    logic signed [COEF_W-1:0] mul_c;
    logic signed [DATA_W-1:0] mul_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_d;

    always_comb begin
        mul_c = '0;
        mul_x = '0;
        case (cnt_q)
            3'd0:    begin mul_c = coef_q[0]; mul_x = x0_q; end
            3'd1:    begin mul_c = coef_q[1]; mul_x = x1_q; end
            3'd2:    begin mul_c = coef_q[2]; mul_x = x2_q; end
            3'd3:    begin mul_c = coef_q[3]; mul_x = y1_q; end
            3'd4:    begin mul_c = coef_q[4]; mul_x = y2_q; end
            default: begin mul_c = '0;        mul_x = '0;   end
        endcase
    end

    assign prod     = mul_c * mul_x;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // Feedback terms (steps 3 and 4) are subtracted.
    assign acc_d    = (cnt_q >= 3'd3) ? (acc_q - prod_ext) : (acc_q + prod_ext);

    logic signed [ACC_W-1:0]  round_sum;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [DATA_W-1:0] y_sat_d;
    logic                     sat_d;

    assign round_sum = acc_q + RND;
    assign rounded   = round_sum >>> FRAC;

    always_comb begin
        y_sat_d = rounded[DATA_W-1:0];
        sat_d   = 1'b0;
        if (rounded > Y_MAX) begin
            y_sat_d = Y_MAX[DATA_W-1:0];
            sat_d   = 1'b1;
        end else if (rounded < Y_MIN) begin
            y_sat_d = Y_MIN[DATA_W-1:0];
            sat_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            acc_q       <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x0_q    <= bus.x_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd4) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    y_out_q     <= y_sat_d;
                    sat_q       <= sat_d;
                    out_valid_q <= 1'b1;
                    x2_q        <= x1_q;
                    x1_q        <= x0_q;
                    y2_q        <= y1_q;
                    y1_q        <= y_sat_d;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.y_out     = y_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat       = sat_q;
endmodule
